// File: rtl/fetch_ifid.sv
// fetch_ifid: PC + imem request handshake, IF/ID register with one-entry skid, branch redirect; 1 instr/cycle, valid_d 2 edges after reset.
// Stall holds IF/ID and parks a returned word in the skid; FETCH_MISALIGN_TRAP_EN enables the misaligned-redirect FAULT state.
module fetch_ifid #(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_rdata,
  input  logic            stall_d,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            valid_d,
  output logic [31:0]     instr_d,
  output logic [PC_W-1:0] pc_d,
  output logic [10:0]     op_d,
  output logic            fetch_fault
);

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_DRAIN
`ifdef FETCH_MISALIGN_TRAP_EN
    , S_FAULT
`endif
  } state_t;

  state_t          state, state_nxt, resume_st;
  logic [PC_W-1:0] pc, drain_pc, redir_tgt;
  entry_t          skid;
  logic            accept, redir_live;

  assign accept = !valid_d || !stall_d;
  assign op_d   = instr_d[31:21];

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q, trap;
  // Once a fault is pending, further redirects are ignored; only reset clears it.
  assign redir_live  = redirect && !fault_q;
  assign trap        = redir_live && (redirect_pc[1:0] != 2'b00);
  assign redir_tgt   = redirect_pc;
  assign resume_st   = (fault_q || trap) ? S_FAULT : S_REQ;
  assign fetch_fault = fault_q;
`else
  assign redir_live  = redirect;
  assign redir_tgt   = redirect_pc & ~(PC_W'(3));
  assign resume_st   = S_REQ;
  assign fetch_fault = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = resume_st;
      S_REQ: begin
        // A redirect with no response yet must drain the in-flight request first.
        if (redir_live)                    state_nxt = imem_valid ? resume_st : S_DRAIN;
        else if (imem_valid && !accept)    state_nxt = S_HOLD;
      end
      S_HOLD:  if (redir_live || !stall_d) state_nxt = resume_st;
      S_DRAIN: if (imem_valid)             state_nxt = resume_st;
      default: state_nxt = state;
    endcase
  end

  always_comb begin
    imem_req  = (state == S_REQ) || (state == S_DRAIN);
    imem_addr = (state == S_DRAIN) ? drain_pc : pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      drain_pc <= '0;
      skid     <= '0;
      valid_d  <= 1'b0;
      instr_d  <= '0;
      pc_d     <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q  <= 1'b0;
`endif
    end else if (redir_live) begin
      pc      <= redir_tgt;
      valid_d <= 1'b0;
      skid    <= '0;
      if (state == S_REQ && !imem_valid) drain_pc <= pc;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (trap) fault_q <= 1'b1;
`endif
    end else begin
      case (state)
        S_REQ: begin
          if (imem_valid) begin
            if (accept) begin
              instr_d <= imem_rdata;
              pc_d    <= pc;
              valid_d <= 1'b1;
            end else begin
              skid <= '{instr: imem_rdata, pc: pc};
            end
            pc <= pc + PC_W'(4);
          end else if (accept) begin
            valid_d <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall_d) begin
            instr_d <= skid.instr;
            pc_d    <= skid.pc;
            valid_d <= 1'b1;
          end
        end
        default: if (accept) valid_d <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ifid.sv
// Directed bench for fetch_ifid: memory returns 0xF8400000|addr with programmable latency.
module tb_fetch_ifid;
  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        stall_d;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        valid_d;
  logic [31:0] instr_d;
  logic [63:0] pc_d;
  logic [10:0] op_d;
  logic        fetch_fault;

  int lat = 0;
  int lat_cnt = 0;
  int tests_run = 0;
  int tests_failed = 0;

  fetch_ifid #(.PC_W(64), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .stall_d(stall_d), .redirect(redirect), .redirect_pc(redirect_pc),
    .valid_d(valid_d), .instr_d(instr_d), .pc_d(pc_d), .op_d(op_d),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset || !imem_req || imem_valid) lat_cnt <= 0;
    else                                  lat_cnt <= lat_cnt + 1;
  end
  assign imem_valid = imem_req && (lat_cnt >= lat);
  assign imem_rdata = 32'hF840_0000 | imem_addr[31:0];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int n;
    reset = 1'b1; stall_d = 1'b0; redirect = 1'b0; redirect_pc = '0;
    cyc(2);
    check("rst_valid", valid_d, 1'b0);
    check("rst_req", imem_req, 1'b0);
    check("rst_pc_d", pc_d, 64'h0);
    check("rst_instr", instr_d, 32'h0);
    check("rst_fault", fetch_fault, 1'b0);

    // 1: zero-wait fetch stream
    reset = 1'b0;
    cyc(1);
    check("t1_req", imem_req, 1'b1);
    check("t1_addr", imem_addr, 64'h0);
    check("t1_notyet", valid_d, 1'b0);
    cyc(1);
    check("t1_valid", valid_d, 1'b1);
    check("t1_pc0", pc_d, 64'h0);
    check("t1_instr0", instr_d, 32'hF840_0000);
    check("t1_op", op_d, 11'h7C2);
    cyc(1);
    check("t1_pc4", pc_d, 64'h4);

    // 2: stall three cycles with pc_d=4
    stall_d = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("t2_hold_pc", pc_d, 64'h4);
      check("t2_hold_instr", instr_d, 32'hF840_0004);
      check("t2_hold_req", imem_req, 1'b0);
    end
    stall_d = 1'b0;
    cyc(1);
    check("t2_pc8", pc_d, 64'h8);
    check("t2_v8", valid_d, 1'b1);
    cyc(1);
    check("t2_pc12", pc_d, 64'hC);
    cyc(1);
    check("t3_pc16", pc_d, 64'h10);

    // 3: redirect while pc_d=0x10
    redirect = 1'b1; redirect_pc = 64'h40;
    cyc(1);
    redirect = 1'b0;
    check("t3_flush", valid_d, 1'b0);
    check("t3_addr", imem_addr, 64'h40);
    cyc(1);
    check("t3_valid", valid_d, 1'b1);
    check("t3_pc40", pc_d, 64'h40);
    check("t3_instr40", instr_d, 32'hF840_0040);

    // 4: 3-cycle memory, redirect during the outstanding request
    lat = 3;
    cyc(1);
    check("t4_addr_a", imem_addr, 64'h44);
    redirect = 1'b1; redirect_pc = 64'h40;
    cyc(1);
    redirect = 1'b0;
    check("t4_drain_addr", imem_addr, 64'h44);
    check("t4_drain_req", imem_req, 1'b1);
    check("t4_drain_v", valid_d, 1'b0);
    cyc(1);
    check("t4_resp", imem_valid, 1'b1);
    check("t4_addr_hold", imem_addr, 64'h44);
    cyc(1);
    check("t4_new_addr", imem_addr, 64'h40);
    check("t4_stale_drop", valid_d, 1'b0);
    n = 0;
    while (!valid_d && n < 10) begin
      cyc(1);
      n++;
    end
    check("t4_valid", valid_d, 1'b1);
    check("t4_pc", pc_d, 64'h40);
    check("t4_instr", instr_d, 32'hF840_0040);

    // 5: reset with a request outstanding
    check("t5_pending", imem_req && !imem_valid, 1'b1);
    reset = 1'b1;
    cyc(1);
    check("t5_valid", valid_d, 1'b0);
    check("t5_req", imem_req, 1'b0);
    reset = 1'b0; lat = 0;
    cyc(1);
    check("t5_addr", imem_addr, 64'h0);
    cyc(1);
    check("t5_pc_d", pc_d, 64'h0);
    check("t5_v", valid_d, 1'b1);

    // PC wrap at the top of the address space
    redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    cyc(1);
    redirect = 1'b0;
    cyc(1);
    check("wrap_pc_top", pc_d, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_op", op_d, 11'h7FF);
    cyc(1);
    check("wrap_pc0", pc_d, 64'h0);

    // 6: misaligned redirect
    redirect = 1'b1; redirect_pc = 64'h42;
    cyc(1);
    redirect = 1'b0;
    check("t6_flush", valid_d, 1'b0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("t6_fault", fetch_fault, 1'b1);
    check("t6_req", imem_req, 1'b0);
    cyc(3);
    check("t6_req_later", imem_req, 1'b0);
    check("t6_fault_sticky", fetch_fault, 1'b1);
    check("t6_valid_later", valid_d, 1'b0);
`else
    check("t6_nofault", fetch_fault, 1'b0);
    check("t6_addr", imem_addr, 64'h40);
    cyc(1);
    check("t6_valid", valid_d, 1'b1);
    check("t6_pc", pc_d, 64'h40);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
